// File: rtl/rv32i_decode_stage.sv
// -----------------------------------------------------------------------------
// rv32i_decode_stage
//
// Registered RV32I decode stage sitting between fetch and execute. One
// instruction (plus its PC) is accepted per valid/ready handshake, decoded
// combinationally and captured into an output register one cycle later.
// The output register holds under downstream backpressure and can be
// discarded with i_flush.
//
// Ports:
//   i_clk          clock, all state on the rising edge
//   i_rst_n        synchronous active-low reset
//   i_flush        drop the held result and ignore this cycle's input
//   i_valid        upstream instruction valid
//   o_ready        stage can accept this cycle (!o_valid || i_ready)
//   i_instruction  raw 32-bit instruction word
//   i_pc           PC of i_instruction (passed through unchanged)
//   o_valid        decoded result valid
//   i_ready        downstream accepts the result
//   o_pc           registered PC
//   o_opcode/o_rd/o_funct3/o_rs1/o_rs2/o_funct7
//                  raw instruction bit slices, legal or not
//   o_immediate    sign-extended immediate (0 for R-type and illegal)
//   o_format       0=R 1=I 2=S 3=B 4=U 5=J 7=invalid
//   o_rs1_used     rs1 is read
//   o_rs2_used     rs2 is read
//   o_rd_we        rd is written and rd != 0
//   o_illegal      instruction outside the RV32I base set
// -----------------------------------------------------------------------------
module rv32i_decode_stage #(
  parameter int XLEN     = 32,  // must be >= 32
  parameter int PC_WIDTH = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_flush,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [31:0]         i_instruction,
  input  logic [PC_WIDTH-1:0] i_pc,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic [6:0]          o_opcode,
  output logic [4:0]          o_rd,
  output logic [2:0]          o_funct3,
  output logic [4:0]          o_rs1,
  output logic [4:0]          o_rs2,
  output logic [6:0]          o_funct7,
  output logic [XLEN-1:0]     o_immediate,
  output logic [2:0]          o_format,
  output logic                o_rs1_used,
  output logic                o_rs2_used,
  output logic                o_rd_we,
  output logic                o_illegal
);

  // Major opcodes
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  // Format codes
  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_INV = 3'd7;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ---------------------------------------------------------------------------
  // Raw field slices
  // ---------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [6:0] funct7;

  assign opcode = i_instruction[6:0];
  assign rd     = i_instruction[11:7];
  assign funct3 = i_instruction[14:12];
  assign rs1    = i_instruction[19:15];
  assign rs2    = i_instruction[24:20];
  assign funct7 = i_instruction[31:25];

  // ---------------------------------------------------------------------------
  // Format classification and legality
  // ---------------------------------------------------------------------------
  logic [2:0] raw_fmt;       // format implied by opcode alone
  logic       raw_illegal;
  logic       is_shift_imm;  // SLLI/SRLI/SRAI: immediate is the shamt
  logic       is_no_rs1_rd;  // SYSTEM / MISC-MEM: I-format but no rs1/rd use

  always_comb begin
    raw_fmt      = FMT_INV;
    raw_illegal  = 1'b0;
    is_shift_imm = 1'b0;
    is_no_rs1_rd = 1'b0;

    if (i_instruction[1:0] != 2'b11) begin
      raw_illegal = 1'b1;
    end else begin
      case (opcode)
        OPC_OP: begin
          raw_fmt = FMT_R;
          if (funct7 == F7_ALT) begin
            // Only SUB (000) and SRA (101) have the alternate funct7
            if (funct3 != 3'b000 && funct3 != 3'b101) raw_illegal = 1'b1;
          end else if (funct7 != F7_ZERO) begin
            raw_illegal = 1'b1;
          end
        end

        OPC_OP_IMM: begin
          raw_fmt = FMT_I;
          if (funct3 == 3'b001) begin
            is_shift_imm = 1'b1;
            if (funct7 != F7_ZERO) raw_illegal = 1'b1;
          end else if (funct3 == 3'b101) begin
            is_shift_imm = 1'b1;
            if (funct7 != F7_ZERO && funct7 != F7_ALT) raw_illegal = 1'b1;
          end
        end

        OPC_LOAD: begin
          raw_fmt = FMT_I;
          if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
            raw_illegal = 1'b1;
        end

        OPC_JALR: begin
          raw_fmt = FMT_I;
          if (funct3 != 3'b000) raw_illegal = 1'b1;
        end

        OPC_SYSTEM, OPC_MISC_MEM: begin
          raw_fmt      = FMT_I;
          is_no_rs1_rd = 1'b1;
        end

        OPC_STORE: begin
          raw_fmt = FMT_S;
          if (funct3 > 3'b010) raw_illegal = 1'b1;
        end

        OPC_BRANCH: begin
          raw_fmt = FMT_B;
          if (funct3 == 3'b010 || funct3 == 3'b011) raw_illegal = 1'b1;
        end

        OPC_LUI, OPC_AUIPC: raw_fmt = FMT_U;

        OPC_JAL: raw_fmt = FMT_J;

        default: raw_illegal = 1'b1;
      endcase
    end
  end

  // An illegal instruction collapses to the invalid format so the immediate
  // and use-flag logic below only has to look at one signal.
  logic [2:0] dec_fmt;
  assign dec_fmt = raw_illegal ? FMT_INV : raw_fmt;

  // ---------------------------------------------------------------------------
  // Immediate generation (32-bit, then sign-extended to XLEN)
  // ---------------------------------------------------------------------------
  logic [31:0]     imm32;
  logic [XLEN-1:0] dec_imm;

  always_comb begin
    imm32 = 32'd0;
    case (dec_fmt)
      FMT_I: begin
        if (is_shift_imm)
          imm32 = {27'd0, i_instruction[24:20]};
        else
          imm32 = {{20{i_instruction[31]}}, i_instruction[31:20]};
      end
      FMT_S: imm32 = {{20{i_instruction[31]}}, i_instruction[31:25],
                      i_instruction[11:7]};
      FMT_B: imm32 = {{19{i_instruction[31]}}, i_instruction[31],
                      i_instruction[7], i_instruction[30:25],
                      i_instruction[11:8], 1'b0};
      FMT_U: imm32 = {i_instruction[31:12], 12'd0};
      FMT_J: imm32 = {{11{i_instruction[31]}}, i_instruction[31],
                      i_instruction[19:12], i_instruction[20],
                      i_instruction[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
  end

  // Replicating bit 31 (XLEN-31) times keeps the replication count >= 1
  // even when XLEN == 32. Shamt immediates have bit 31 clear, so they
  // come out zero-extended.
  assign dec_imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

  // ---------------------------------------------------------------------------
  // Operand-use flags
  // ---------------------------------------------------------------------------
  logic dec_rs1_used;
  logic dec_rs2_used;
  logic dec_rd_we;

  always_comb begin
    dec_rs1_used = 1'b0;
    dec_rs2_used = 1'b0;
    dec_rd_we    = 1'b0;
    case (dec_fmt)
      FMT_R: begin
        dec_rs1_used = 1'b1;
        dec_rs2_used = 1'b1;
        dec_rd_we    = 1'b1;
      end
      FMT_I: begin
        dec_rs1_used = !is_no_rs1_rd;
        dec_rd_we    = !is_no_rs1_rd;
      end
      FMT_S, FMT_B: begin
        dec_rs1_used = 1'b1;
        dec_rs2_used = 1'b1;
      end
      FMT_U, FMT_J: dec_rd_we = 1'b1;
      default: ;
    endcase
    // Writes to x0 are architecturally discarded
    if (rd == 5'd0) dec_rd_we = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Handshake and output register
  // ---------------------------------------------------------------------------
  logic                valid_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [6:0]          opcode_q;
  logic [4:0]          rd_q;
  logic [2:0]          funct3_q;
  logic [4:0]          rs1_q;
  logic [4:0]          rs2_q;
  logic [6:0]          funct7_q;
  logic [XLEN-1:0]     imm_q;
  logic [2:0]          format_q;
  logic                rs1_used_q;
  logic                rs2_used_q;
  logic                rd_we_q;
  logic                illegal_q;

  logic ready;
  logic load;
  logic valid_d;

  assign ready = !valid_q || i_ready;
  assign load  = i_valid && ready && !i_flush;

  always_comb begin
    valid_d = valid_q;
    if (i_flush)
      valid_d = 1'b0;
    else if (load)
      valid_d = 1'b1;
    else if (valid_q && i_ready)
      valid_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      opcode_q   <= '0;
      rd_q       <= '0;
      funct3_q   <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      funct7_q   <= '0;
      imm_q      <= '0;
      format_q   <= '0;
      rs1_used_q <= 1'b0;
      rs2_used_q <= 1'b0;
      rd_we_q    <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      // Data fields only move on a load; on flush or drain they keep their
      // stale contents, which downstream ignores because o_valid is low.
      if (load) begin
        pc_q       <= i_pc;
        opcode_q   <= opcode;
        rd_q       <= rd;
        funct3_q   <= funct3;
        rs1_q      <= rs1;
        rs2_q      <= rs2;
        funct7_q   <= funct7;
        imm_q      <= dec_imm;
        format_q   <= dec_fmt;
        rs1_used_q <= dec_rs1_used;
        rs2_used_q <= dec_rs2_used;
        rd_we_q    <= dec_rd_we;
        illegal_q  <= raw_illegal;
      end
    end
  end

  assign o_ready     = ready;
  assign o_valid     = valid_q;
  assign o_pc        = pc_q;
  assign o_opcode    = opcode_q;
  assign o_rd        = rd_q;
  assign o_funct3    = funct3_q;
  assign o_rs1       = rs1_q;
  assign o_rs2       = rs2_q;
  assign o_funct7    = funct7_q;
  assign o_immediate = imm_q;
  assign o_format    = format_q;
  assign o_rs1_used  = rs1_used_q;
  assign o_rs2_used  = rs2_used_q;
  assign o_rd_we     = rd_we_q;
  assign o_illegal   = illegal_q;

endmodule
